pixel_word_packer: RTL

PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

---
 rtl/pixel_word_packer_pkg.sv | 17 +
 rtl/pixel_word_packer_if.sv | 32 +++
 rtl/pixel_word_packer_lane_accumulator.sv | 53 +++++
 rtl/pixel_word_packer.sv | 60 ++++++
 4 files changed

// File: rtl/pixel_word_packer_pkg.sv
// Shared parameters and width helpers for the pixel word packer.
// The output-word and lane-count widths are derived here so every file agrees on them.
package pixel_word_packer_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_LANES = 5;

    function automatic int out_width(input int in_w, input int lanes);
        return in_w * lanes;
    endfunction

    // Wide enough to hold a lane count from 0 up to and including LANES.
    function automatic int count_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// Lane-in / word-out handshake bundle for the pixel word packer.
interface pixel_word_packer_if
    import pixel_word_packer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int LANES = DEF_LANES
);

    localparam int OUT_W = out_width(IN_W, LANES);
    localparam int CW    = count_width(LANES);

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_last, out_valid
    );

endinterface

// File: rtl/pixel_word_packer_lane_accumulator.sv
// Lane counter plus partial-word register; presents the word that would complete
// with the current lane so the top can capture it in the same cycle.
module lane_accumulator
    import pixel_word_packer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int LANES = DEF_LANES,
    parameter int OUT_W = out_width(IN_W, LANES),
    parameter int CW    = count_width(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  lane_data,
    input  logic             take,
    input  logic             last,
    output logic             complete,
    output logic [OUT_W-1:0] word,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(LANES - 1);

    logic [CW-1:0]    lane_idx;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] placed;

    // The first lane of a word sits in the MSBs; later lanes fill downward.
    always_comb begin
        placed = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_idx == CW'(k)) begin
                placed[OUT_W-1-k*IN_W -: IN_W] = lane_data;
            end
        end
        word     = acc | placed;
        count    = lane_idx + CW'(1);
        complete = take && (last || (lane_idx == LAST_IDX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx <= '0;
            acc      <= '0;
        end else if (complete) begin
            lane_idx <= '0;
            acc      <= '0;
        end else if (take) begin
            lane_idx <= lane_idx + CW'(1);
            acc      <= word;
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs IN_W-bit pixel lanes into LANES-wide words, MSB-first, with one output
// register stage; in_last flushes a zero-padded partial word.
module pixel_word_packer
    import pixel_word_packer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int LANES = DEF_LANES
) (
    input logic               clk,
    input logic               rst,
    pixel_word_packer_if.slave bus
);

    localparam int OUT_W = out_width(IN_W, LANES);
    localparam int CW    = count_width(LANES);

    logic             take;
    logic             complete;
    logic [OUT_W-1:0] word;
    logic [CW-1:0]    count;

    // Input is stalled whenever a finished word is still waiting downstream.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign take         = bus.in_valid && bus.in_ready;

    lane_accumulator #(
        .IN_W  (IN_W),
        .LANES (LANES),
        .OUT_W (OUT_W),
        .CW    (CW)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .lane_data (bus.in_data),
        .take      (take),
        .last      (bus.in_last),
        .complete  (complete),
        .word      (word),
        .count     (count)
    );

    // A completing lane can only be taken when the register is free or draining,
    // so loading here never overwrites an undelivered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_last  <= 1'b0;
        end else if (complete) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= word;
            bus.out_count <= count;
            bus.out_last  <= bus.in_last;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
